apu_frame_seq_m: RTL and testbench
==================================

Name: apu_frame_seq_m

Overview:
- Timing scheduler for the APU channel datapaths.
- Derives the 512 Hz frame-sequencer step from the system counter and issues single-cycle length, sweep and envelope strobes to all four channels.
- Owns the four per-channel length counters and reports channel-active status for NR52[3:0].
- Sits inside the APU MMIO block, between the register file (write/trigger events) and the channel generators (which consume the strobes).

Parameters:
- FS_BIT, 12, bit of sys_counter whose falling edge advances the sequencer (DIV bit 4 → 512 Hz).
- WAVE_CH, 2, index of the channel with the 256-step length counter; all others use 64 steps.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sys_counter  in  32  free-running system counter
- apu_enable  in  1  NR52[7] master power
- len_load  in  4  one-hot per channel: load length from len_data this cycle (NRx1 write)
- len_data  in  8  raw NRx1 length field (6 LSBs used for non-wave channels)
- len_en  in  4  per-channel length-enable (NRx4[6])
- trigger  in  4  one-hot per channel trigger pulse (NRx4[7] write)
- dac_off  in  4  per-channel DAC disabled; forces channel inactive
- fs_step  out  3  current sequencer step
- length_tick  out  1  strobe on steps 0, 2, 4, 6
- sweep_tick  out  1  strobe on steps 2, 6
- env_tick  out  1  strobe on step 7
- ch_active  out  4  channel-enabled status

Behaviour:
- Reset: fs_step=0, all strobes 0, ch_active=0, all length counters 0, edge-detect register 0.
- Edge detect: register sys_counter[FS_BIT] each cycle. A falling edge is prev=1 && cur=0.
- Stepping:
  - On a falling edge with apu_enable=1, fs_step increments, wrapping 7→0.
  - In the next cycle, exactly one cycle of the strobe(s) for the new step is asserted. Latency is 1 cycle from edge detection to strobe.
  - Strobes are never asserted for more than one cycle per step.
- Step table: 0 → length; 1 → none; 2 → length+sweep; 3 → none; 4 → length; 5 → none; 6 → length+sweep; 7 → env.
- Power-off (apu_enable=0):
  - fs_step is forced to 0 and strobes are suppressed.
  - All length counters and ch_active are cleared.
  - len_load and trigger are ignored.
  - The edge register keeps tracking, so re-enabling mid-period does not generate a spurious step.
- Length counter (per channel i; max M = 256 for WAVE_CH, else 64). The counter is 9 bits for WAVE_CH and 7 bits otherwise, so M fits.
  - len_load[i]: counter ← M − len_data. Non-wave channels use len_data[5:0]. Range is 1..M. ch_active is unchanged.
  - trigger[i]: if counter==0, counter ← M. ch_active[i] ← !dac_off[i].
  - length_tick with len_en[i]=1 and counter≠0: decrement. If the result is 0, ch_active[i] ← 0.
  - Priority within one cycle: trigger > len_load > tick. A tick coinciding with a trigger or load is dropped for that channel.
  - len_en=0: the counter holds its value.
  - Counter==0 with a tick: no change and no underflow.
- dac_off[i]=1: ch_active[i] is cleared the same cycle and stays 0; the counter is unaffected.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package apu_pkg:
  - FS_LEN_STEPS mask 8'b0101_0101
  - FS_SWEEP_STEPS 8'b0100_0100
  - FS_ENV_STEPS 8'b1000_0000
  - LEN_MAX_SQ=64, LEN_MAX_WAVE=256
  - Channel index enum CH1..CH4.
- One sub-module, apu_length_ctr_m (parameter MAX), instantiated four times. It holds the counter, priority logic and active flag.

Test Plan:
- Toggle sys_counter[12] 1→0 eight times → fs_step walks 1..7,0. length_tick on steps 2,4,6,0; sweep_tick on 2,6; env_tick on 7. Each strobe is 1 cycle wide, one cycle after the edge.
- CH2: len_load with len_data=8'h3E, len_en=1, trigger → counter=2, ch_active[1]=1. After 2 length_ticks, ch_active[1]=0 and the counter holds 0 on further ticks.
- WAVE_CH: len_data=0, trigger → counter=256. 256 ticks → inactive. len_en=0 across 10 ticks → counter unchanged.
- Trigger and length_tick in the same cycle on CH1 with counter=0 → counter=64, no decrement that cycle, ch_active[0]=1.
- apu_enable dropped at fs_step=5 → fs_step=0, ch_active=0, no strobes while low. Re-enable with sys_counter[12] low → the first strobe appears only after the next genuine 1→0 edge, with fs_step=1.
- dac_off[3]=1 during trigger → ch_active[3] stays 0 and the counter loads 64.
- rst asserted mid-count → all outputs 0 on the following cycle.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU timing definitions: frame-sequencer step tables, length maxima,
// channel indices and the step-to-strobe decode.
package apu_pkg;

  localparam logic [7:0] FS_LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_STEPS   = 8'b1000_0000;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  typedef enum logic [1:0] {
    CH1 = 2'd0,
    CH2 = 2'd1,
    CH3 = 2'd2,
    CH4 = 2'd3
  } apu_ch_e;

  typedef struct packed {
    logic length;
    logic sweep;
    logic env;
  } fs_ticks_t;

  function automatic fs_ticks_t fs_decode(input logic [2:0] step);
    fs_ticks_t t;
    t.length = FS_LEN_STEPS[step];
    t.sweep  = FS_SWEEP_STEPS[step];
    t.env    = FS_ENV_STEPS[step];
    return t;
  endfunction

endpackage

// File: rtl/apu_length_ctr_m.sv
// One channel's length counter and active flag. Priority within a cycle is
// trigger, then length load, then length tick.
module apu_length_ctr_m #(
  parameter int  MAX = 64,
  localparam int DW  = $clog2(MAX),
  localparam int CW  = DW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          apu_enable,
  input  logic          len_load,
  input  logic [DW-1:0] len_data,
  input  logic          len_en,
  input  logic          trigger,
  input  logic          dac_off,
  input  logic          length_tick,
  output logic          active
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);
  localparam logic [CW-1:0] ONE_V = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active;
    if (!apu_enable) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (trigger) begin
      if (cnt_q == '0) cnt_d = MAX_V;
      active_d = 1'b1;
    end else if (len_load) begin
      // A written length of 0 means a full MAX-step run.
      cnt_d = MAX_V - {1'b0, len_data};
    end else if (length_tick && len_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_V;
      if (cnt_q == ONE_V) active_d = 1'b0;
    end
    if (dac_off) active_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      active <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      active <= active_d;
    end
  end

endmodule

// File: rtl/apu_frame_seq_m.sv
// APU frame sequencer: steps on falling edges of sys_counter[FS_BIT], emits
// one-cycle length/sweep/envelope strobes and owns the per-channel length counters.
module apu_frame_seq_m
  import apu_pkg::*;
#(
  parameter int FS_BIT  = 12,
  parameter int WAVE_CH = int'(CH3)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_counter,
  input  logic        apu_enable,
  input  logic [3:0]  len_load,
  input  logic [7:0]  len_data,
  input  logic [3:0]  len_en,
  input  logic [3:0]  trigger,
  input  logic [3:0]  dac_off,
  output logic [2:0]  fs_step,
  output logic        length_tick,
  output logic        sweep_tick,
  output logic        env_tick,
  output logic [3:0]  ch_active
);

  logic      fs_prev;
  logic      fs_fall;
  logic [2:0] step_d;
  fs_ticks_t ticks_d;
  fs_ticks_t ticks_q;
  logic      unused_sys_bits;

  assign unused_sys_bits = ^{sys_counter[31:FS_BIT+1], sys_counter[FS_BIT-1:0]};

  // The edge register runs even while powered off so re-enabling never fakes a step.
  assign fs_fall = fs_prev & ~sys_counter[FS_BIT];

  always_comb begin
    step_d  = fs_step;
    ticks_d = '0;
    if (!apu_enable) begin
      step_d = 3'd0;
    end else if (fs_fall) begin
      step_d  = fs_step + 3'd1;
      ticks_d = fs_decode(step_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_prev <= 1'b0;
      fs_step <= 3'd0;
      ticks_q <= '0;
    end else begin
      fs_prev <= sys_counter[FS_BIT];
      fs_step <= step_d;
      ticks_q <= ticks_d;
    end
  end

  assign length_tick = ticks_q.length;
  assign sweep_tick  = ticks_q.sweep;
  assign env_tick    = ticks_q.env;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (i == WAVE_CH) begin : g_wave
      apu_length_ctr_m #(.MAX(LEN_MAX_WAVE)) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .apu_enable  (apu_enable),
        .len_load    (len_load[i]),
        .len_data    (len_data),
        .len_en      (len_en[i]),
        .trigger     (trigger[i]),
        .dac_off     (dac_off[i]),
        .length_tick (ticks_q.length),
        .active      (ch_active[i])
      );
    end else begin : g_sq
      apu_length_ctr_m #(.MAX(LEN_MAX_SQ)) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .apu_enable  (apu_enable),
        .len_load    (len_load[i]),
        .len_data    (len_data[5:0]),
        .len_en      (len_en[i]),
        .trigger     (trigger[i]),
        .dac_off     (dac_off[i]),
        .length_tick (ticks_q.length),
        .active      (ch_active[i])
      );
    end
  end

endmodule

// File: tb/tb_apu_frame_seq_m.sv
// Bench for apu_frame_seq_m: directed scenarios plus random traffic, each
// cycle compared against a step/counter model built from the sequencer rules.
module tb_apu_frame_seq_m;

  localparam int FS_BIT  = 12;
  localparam int WAVE_CH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] sys_counter;
  logic        apu_enable;
  logic [3:0]  len_load;
  logic [7:0]  len_data;
  logic [3:0]  len_en;
  logic [3:0]  trigger;
  logic [3:0]  dac_off;
  logic [2:0]  fs_step;
  logic        length_tick;
  logic        sweep_tick;
  logic        env_tick;
  logic [3:0]  ch_active;
  logic [9:0]  dut_vec;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_step;
  bit m_prev, m_len, m_sweep, m_env;
  int m_cnt[4];
  bit m_act[4];

  assign dut_vec = {fs_step, length_tick, sweep_tick, env_tick, ch_active};

  apu_frame_seq_m #(.FS_BIT(FS_BIT), .WAVE_CH(WAVE_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .sys_counter (sys_counter),
    .apu_enable  (apu_enable),
    .len_load    (len_load),
    .len_data    (len_data),
    .len_en      (len_en),
    .trigger     (trigger),
    .dac_off     (dac_off),
    .fs_step     (fs_step),
    .length_tick (length_tick),
    .sweep_tick  (sweep_tick),
    .env_tick    (env_tick),
    .ch_active   (ch_active)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [9:0] exp_vec();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = m_act[i];
    return {m_step[2:0], m_len, m_sweep, m_env, a};
  endfunction

  // Advances the model with the inputs currently driven, then clocks the DUT.
  task automatic step_clk();
    bit cur, old_len;
    int mx, d;
    cur     = sys_counter[FS_BIT];
    old_len = m_len;
    if (rst) begin
      m_step = 0; m_prev = 0; m_len = 0; m_sweep = 0; m_env = 0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_act[i] = 0; end
    end else if (!apu_enable) begin
      m_step = 0; m_len = 0; m_sweep = 0; m_env = 0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_act[i] = 0; end
      m_prev = cur;
    end else begin
      m_len = 0; m_sweep = 0; m_env = 0;
      if (m_prev && !cur) begin
        m_step  = (m_step + 1) % 8;
        m_len   = (m_step % 2 == 0);
        m_sweep = (m_step == 2 || m_step == 6);
        m_env   = (m_step == 7);
      end
      for (int i = 0; i < 4; i++) begin
        mx = (i == WAVE_CH) ? 256 : 64;
        d  = (i == WAVE_CH) ? int'(len_data) : int'(len_data) % 64;
        if (trigger[i]) begin
          if (m_cnt[i] == 0) m_cnt[i] = mx;
          m_act[i] = !dac_off[i];
        end else if (len_load[i]) begin
          m_cnt[i] = mx - d;
        end else if (old_len && len_en[i] && m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) m_act[i] = 0;
        end
        if (dac_off[i]) m_act[i] = 0;
      end
      m_prev = cur;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fs(input bit b);
    sys_counter         = $urandom;
    sys_counter[FS_BIT] = b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    n_checks++;
    if (dut_vec !== 10'd0) begin
      n_errors++;
      $display("FAIL reset: got %b expected %b", dut_vec, 10'd0);
    end
    rst = 1'b0;
    apu_enable = 1'b1;
    set_fs(1'b0);
    step_clk();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_release: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_step_walk();
    int len_n, sw_n, env_n;
    len_n = 0; sw_n = 0; env_n = 0;
    for (int c = 0; c < 32; c++) begin
      set_fs((c % 4) < 2);
      step_clk();
      len_n += int'(length_tick);
      sw_n  += int'(sweep_tick);
      env_n += int'(env_tick);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL step_walk c=%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (len_n != 4 || sw_n != 2 || env_n != 1 || fs_step !== 3'd0) begin
      n_errors++;
      $display("FAIL step_walk_totals: got len=%0d sweep=%0d env=%0d step=%0d expected 4 2 1 0",
               len_n, sw_n, env_n, fs_step);
    end
  endtask

  task automatic test_ch2_length();
    int consumed;
    bit pre;
    len_en   = 4'b0010;
    len_data = 8'h3E;
    len_load = 4'b0010;
    set_fs(1'b0);
    step_clk();
    len_load = 4'b0000;
    trigger  = 4'b0010;
    step_clk();
    trigger  = 4'b0000;
    n_checks++;
    if (ch_active[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL ch2_trigger: got %b expected 1", ch_active[1]);
    end
    consumed = 0;
    for (int c = 0; c < 200 && consumed < 2; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL ch2_count: got %b expected %b", dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (ch_active[1] !== 1'b0 || consumed != 2) begin
      n_errors++;
      $display("FAIL ch2_expire: got active=%b ticks=%0d expected 0 2", ch_active[1], consumed);
    end
    for (int c = 0; c < 16; c++) begin
      set_fs(bit'(c % 2));
      step_clk();
      n_checks++;
      if (ch_active[1] !== 1'b0 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL ch2_hold: got %b expected %b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wave_length();
    int consumed;
    bit pre;
    len_en   = 4'b0000;
    len_data = 8'h00;
    len_load = 4'b0100;
    step_clk();
    len_load = 4'b0000;
    trigger  = 4'b0100;
    step_clk();
    trigger  = 4'b0000;
    consumed = 0;
    for (int c = 0; c < 200 && consumed < 10; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
    end
    n_checks++;
    if (ch_active[2] !== 1'b1 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL wave_len_en_off: got %b expected %b", dut_vec, exp_vec());
    end
    len_en   = 4'b0100;
    consumed = 0;
    for (int c = 0; c < 2000; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL wave_count: got %b expected %b", dut_vec, exp_vec());
      end
      if (ch_active[2] == 1'b0) break;
    end
    n_checks++;
    if (consumed != 256) begin
      n_errors++;
      $display("FAIL wave_ticks: got %0d expected 256", consumed);
    end
  endtask

  task automatic test_trig_tick();
    int consumed;
    bit pre;
    len_en = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      if (m_len) break;
      set_fs(bit'(c % 2));
      step_clk();
    end
    trigger = 4'b0001;
    set_fs(1'b1);
    step_clk();
    trigger = 4'b0000;
    n_checks++;
    if (ch_active[0] !== 1'b1 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL trig_tick_active: got %b expected %b", dut_vec, exp_vec());
    end
    consumed = 0;
    for (int c = 0; c < 600; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
      if (ch_active[0] == 1'b0) break;
    end
    n_checks++;
    if (consumed != 64) begin
      n_errors++;
      $display("FAIL trig_tick_len: got %0d expected 64", consumed);
    end
  endtask

  task automatic test_power_off();
    len_en  = 4'b0000;
    trigger = 4'b1000;
    step_clk();
    trigger = 4'b0000;
    for (int c = 0; c < 60; c++) begin
      if (m_step == 5) break;
      set_fs(bit'(c % 2));
      step_clk();
    end
    set_fs(1'b1);
    step_clk();
    n_checks++;
    if (fs_step !== 3'd5 || ch_active[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL power_pre: got step=%0d active=%b expected 5 1", fs_step, ch_active[3]);
    end
    apu_enable = 1'b0;
    trigger    = 4'b1111;
    len_load   = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      set_fs(c % 2 == 0);
      step_clk();
      n_checks++;
      if (dut_vec !== 10'd0 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL power_off c=%0d: got %b expected 0", c, dut_vec);
      end
    end
    trigger    = 4'b0000;
    len_load   = 4'b0000;
    apu_enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_fs(1'b0);
      step_clk();
      n_checks++;
      if (dut_vec !== 10'd0) begin
        n_errors++;
        $display("FAIL reenable_quiet: got %b expected 0", dut_vec);
      end
    end
    set_fs(1'b1);
    step_clk();
    set_fs(1'b0);
    step_clk();
    n_checks++;
    if (fs_step !== 3'd1 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL reenable_step: got %b expected step 1 (%b)", dut_vec, exp_vec());
    end
  endtask

  task automatic test_dac_off();
    int consumed;
    bit pre;
    dac_off = 4'b1000;
    len_en  = 4'b0000;
    trigger = 4'b1000;
    step_clk();
    trigger = 4'b0000;
    n_checks++;
    if (ch_active[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL dac_trigger: got %b expected 0", ch_active[3]);
    end
    len_en   = 4'b1000;
    consumed = 0;
    for (int c = 0; c < 200 && consumed < 10; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
      n_checks++;
      if (ch_active[3] !== 1'b0 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL dac_hold: got %b expected %b", dut_vec, exp_vec());
      end
    end
    dac_off = 4'b0000;
    trigger = 4'b1000;
    step_clk();
    trigger = 4'b0000;
    consumed = 0;
    for (int c = 0; c < 600; c++) begin
      set_fs(bit'(c % 2));
      pre = m_len;
      step_clk();
      if (pre) consumed++;
      if (ch_active[3] == 1'b0) break;
    end
    n_checks++;
    if (consumed != 54) begin
      n_errors++;
      $display("FAIL dac_counter: got %0d ticks expected 54", consumed);
    end
  endtask

  task automatic test_reset_mid();
    len_en  = 4'b0111;
    trigger = 4'b0111;
    step_clk();
    trigger = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      set_fs(bit'(c % 2));
      step_clk();
    end
    rst = 1'b1;
    step_clk();
    n_checks++;
    if (dut_vec !== 10'd0 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_mid: got %b expected 0", dut_vec);
    end
    rst = 1'b0;
    step_clk();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      apu_enable = ($urandom_range(0, 40) != 0);
      for (int i = 0; i < 4; i++) begin
        len_load[i] = ($urandom_range(0, 15) == 0);
        trigger[i]  = ($urandom_range(0, 15) == 0);
        dac_off[i]  = ($urandom_range(0, 19) == 0);
      end
      len_data = 8'($urandom);
      len_en   = 4'($urandom);
      set_fs(bit'($urandom_range(0, 1)));
      step_clk();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL random c=%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst        = 1'b1;
    sys_counter = 32'd0;
    apu_enable = 1'b0;
    len_load   = 4'b0000;
    len_data   = 8'h00;
    len_en     = 4'b0000;
    trigger    = 4'b0000;
    dac_off    = 4'b0000;
    m_step = 0; m_prev = 0; m_len = 0; m_sweep = 0; m_env = 0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_act[i] = 0; end

    test_reset();
    test_step_walk();
    test_ch2_length();
    test_wave_length();
    test_trig_tick();
    test_power_off();
    test_dac_off();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
